latch_sipo_capture: RTL
=======================

# latch_sipo_capture

Serial-in/parallel-out capture stage that sits directly downstream of the `d_latch` cell. It consumes the latch's `q_out` as a serial bit stream. It resynchronises that stream into the clock domain and shifts in a programmable number of bits under an enable. It presents the assembled word with a valid/ack handshake to the next stage.

## Interface
- `WIDTH`, default 8: number of data bits per word (2..32).
- `clk_in`  input  1: system clock; all state updates on the rising edge.
- `rst_n_in`  input  1: reset, asynchronous assert, active-low.
- `d_in`  input  1: serial data, driven by the latch `q_out`; asynchronous to `clk_in`.
- `en_in`  input  1: shift enable; one bit is sampled per clock while high in SHIFT.
- `start_in`  input  1: begin a new word capture.
- `ack_in`  input  1: downstream accepts the presented word.
- `par_out`  output  WIDTH: captured word, MSB = first bit received.
- `valid_out`  output  1: `par_out` holds a complete word.
- `busy_out`  output  1: capture in progress (SHIFT or PAR state).
- `parity_err_out`  output  1: parity mismatch on the presented word. Present only with `LATCH_SIPO_PARITY_EN`.

## Operation
- Input sync: `d_in` passes through a 2-flop synchroniser; `d_s` is the second stage. Both flops reset to 0.
- Shift register `sr[WIDTH-1:0]`: on each sampled bit, `sr <= {sr[WIDTH-2:0], d_s}`.
- Bit counter `cnt`: width `$clog2(WIDTH)`. It never exceeds `WIDTH-1` and never wraps.
- FSM states: IDLE, SHIFT, PAR (parity build only), HOLD.
  - IDLE:
    - `start_in`=1 goes to SHIFT; `cnt` and `sr` are cleared.
    - `en_in` is ignored in IDLE.
  - SHIFT:
    - With `en_in`=1, sample `d_s` and increment `cnt`.
    - When `cnt`==WIDTH-1 and `en_in`=1, the last bit is taken. The next state is PAR if parity is built, else HOLD.
    - On entering HOLD, `par_out` loads the final `sr` value including the last bit.
    - With `en_in`=0, hold state and counter.
  - PAR:
    - With `en_in`=1, sample the parity bit `p`.
    - `parity_err_out` <= `(^word) ^ p`, using even parity.
    - Next state is HOLD.
  - HOLD:
    - `valid_out`=1 and `par_out` is stable.
    - `ack_in`=1 goes to IDLE.
    - `ack_in`=1 together with `start_in`=1 goes straight to SHIFT and clears `cnt`/`sr`. `valid_out` drops in that same transition.
- `start_in` is ignored in SHIFT, PAR and HOLD unless `ack_in` is also high in HOLD.
- `ack_in` is ignored outside HOLD.
- `par_out` changes only on entry to HOLD. It keeps its last value through IDLE/SHIFT.

## Timing
- Reset values:
  - `par_out`=0, `valid_out`=0, `busy_out`=0, `parity_err_out`=0.
  - FSM=IDLE, `cnt`=0, `sr`=0, sync flops=0.
- Reset is asynchronous: asserting `rst_n_in` mid-capture clears all state immediately. Any partial word is discarded.
- Sync latency: a change on `d_in` appears at `d_s` two rising edges later. Data must be stable 2 cycles before the enabled sample edge.
- Start to SHIFT: `busy_out` is high on the edge after `start_in` is sampled.
- Capture time, with `en_in` held high: `valid_out` rises 1 + WIDTH cycles after the `start_in` edge. With parity built, it is 1 + WIDTH + 1 cycles.
- All outputs are registered; no combinational path runs from inputs to outputs.
- `valid_out` deasserts on the edge where `ack_in`=1 is sampled in HOLD.

## Configuration
- `LATCH_SIPO_PARITY_EN` defined:
  - PAR state is built and one extra bit is sampled after the data bits.
  - `parity_err_out` port exists. It is updated on entry to HOLD and cleared on the next `start_in` accept.
- `LATCH_SIPO_PARITY_EN` undefined:
  - No PAR state and no `parity_err_out` port.
  - SHIFT goes directly to HOLD after WIDTH bits.

## Test plan
- Reset: hold `rst_n_in`=0 with random `d_in`/`start_in` → all outputs 0. Release, then wait 10 idle cycles → `valid_out`=0, `busy_out`=0.
- Basic word, WIDTH=8: `start_in` pulse, `en_in`=1, serial bits 1,0,1,1,0,0,1,0 (synchronised) → `par_out`=8'hB2, `valid_out`=1 after 9 cycles. `ack_in` pulse → `valid_out`=0 next edge, state IDLE.
- Gapped enable: same stream with `en_in` low every other cycle → `par_out`=8'hB2 after 17 cycles. No extra bits are sampled while `en_in`=0.
- Back-to-back: in HOLD with word 8'hB2, assert `ack_in` and `start_in` together → `valid_out`=0 and `busy_out`=1 next edge. Send 8'h5A → `par_out`=8'h5A.
- Reset mid-op: after 4 bits of 8'hFF, pulse `rst_n_in` low for 1 ns mid-cycle → `busy_out`=0 immediately and `par_out` keeps 0. A following full capture of 8'h0F returns 8'h0F.
- Parity (macro defined): send 8'hB2 (four ones) with parity bit 0 → `parity_err_out`=0. Send 8'hB2 with parity 1 → `parity_err_out`=1 while `valid_out`=1.

Source files
------------

// File: rtl/latch_sipo_capture.sv
`timescale 1ns/1ps
// latch_sipo_capture
// Serial-in/parallel-out capture stage fed by the d_latch q_out.
// The serial stream is resynchronised into clk_in, shifted in under
// en_in for a programmable WIDTH bits, and the finished word is
// presented with a valid/ack handshake.
//
// Build option: LATCH_SIPO_PARITY_EN
//   defined   -> one extra even-parity bit follows the data bits
//                (PAR state), parity_err_out port exists
//   undefined -> SHIFT goes straight to HOLD, no parity_err_out port
//
// Ports
//   clk_in          system clock, rising edge
//   rst_n_in        async active-low reset
//   d_in            serial data, asynchronous to clk_in
//   en_in           shift enable, one bit per clock in SHIFT/PAR
//   start_in        begin a new capture
//   ack_in          downstream accepts the presented word
//   par_out         captured word, MSB = first bit received
//   valid_out       par_out holds a complete word (HOLD)
//   busy_out        capture in progress (SHIFT or PAR)
//   parity_err_out  even-parity mismatch on the presented word
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start_in
// SHIFT | sampling data bits while en_in is high
// PAR   | sampling the parity bit (parity build only)
// HOLD  | word presented on par_out, waiting for ack_in
module latch_sipo_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             d_in,
  input  logic             en_in,
  input  logic             start_in,
  input  logic             ack_in,
  output logic [WIDTH-1:0] par_out,
  output logic             valid_out,
  output logic             busy_out
`ifdef LATCH_SIPO_PARITY_EN
  ,
  output logic             parity_err_out
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             sync_meta_q;
  logic             d_s_q;
  logic [WIDTH-1:0] sr_shift;
`ifdef LATCH_SIPO_PARITY_EN
  logic             perr_q, perr_d;
`endif

  // Two-flop synchroniser; only d_s_q is ever used by the capture logic.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_meta_q <= 1'b0;
      d_s_q       <= 1'b0;
    end else begin
      sync_meta_q <= d_in;
      d_s_q       <= sync_meta_q;
    end
  end

  assign sr_shift = {sr_q[WIDTH-2:0], d_s_q};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      par_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef LATCH_SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef LATCH_SIPO_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
`ifdef LATCH_SIPO_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
`ifdef LATCH_SIPO_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        if (en_in) begin
          sr_d = sr_shift;
          // Counter parks at WIDTH-1 on the last bit instead of wrapping.
          if (cnt_q == CNT_LAST) begin
`ifdef LATCH_SIPO_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_HOLD;
            par_d   = sr_shift;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef LATCH_SIPO_PARITY_EN
      ST_PAR: begin
        if (en_in) begin
          perr_d  = (^sr_q) ^ d_s_q;
          par_d   = sr_q;
          state_d = ST_HOLD;
        end
      end
`endif
      ST_HOLD: begin
        if (ack_in) begin
          if (start_in) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            sr_d    = '0;
`ifdef LATCH_SIPO_PARITY_EN
            perr_d  = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so the outputs come
  // straight from flops.
  always_comb begin
    valid_d = (state_d == ST_HOLD);
    busy_d  = (state_d == ST_SHIFT) || (state_d == ST_PAR);
  end

  assign par_out   = par_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
`ifdef LATCH_SIPO_PARITY_EN
  assign parity_err_out = perr_q;
`endif

endmodule
